// File: rtl/day_to_date.sv
// Day-of-year to month/date decoder. An iterative FSM subtracts month lengths
// one per cycle, which avoids a wide combinational divider.
module day_to_date #(
  parameter int DAY_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DAY_W-1:0] day_idx,
  input  logic             leap,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       month,
  output logic [4:0]       date
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Days in month m; February depends on the latched leap flag.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    logic [4:0] len;
    case (m)
      4'd2:                      len = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   len = 5'd30;
      default:                   len = 5'd31;
    endcase
    return len;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [DAY_W-1:0] rem_r, rem_nxt_s;
  logic [3:0]       mcnt_r, mcnt_nxt_s;
  logic             leap_r, leap_nxt_s;
  logic [3:0]       month_r, month_nxt_s;
  logic [4:0]       date_r, date_nxt_s;
  logic             err_r, err_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;

  logic [4:0]       len_s;
  logic [DAY_W-1:0] limit_s;

  assign len_s   = month_len(mcnt_r, leap_r);
  assign limit_s = DAY_W'(10'd365) + DAY_W'(leap);

  // Next-state and datapath updates; everything holds unless assigned below.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    mcnt_nxt_s  = mcnt_r;
    leap_nxt_s  = leap_r;
    month_nxt_s = month_r;
    date_nxt_s  = date_r;
    err_nxt_s   = err_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          leap_nxt_s = leap;
          err_nxt_s  = 1'b0;
          if (day_idx >= limit_s) begin
            state_nxt_s = DONE;
            err_nxt_s   = 1'b1;
            month_nxt_s = 4'd0;
            date_nxt_s  = 5'd0;
          end else begin
            state_nxt_s = CALC;
            rem_nxt_s   = day_idx;
            mcnt_nxt_s  = 4'd1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (rem_r < DAY_W'(len_s)) begin
          state_nxt_s = DONE;
          month_nxt_s = mcnt_r;
          date_nxt_s  = rem_r[4:0] + 5'd1;
        end else if (mcnt_r >= 4'd12) begin
          // Unreachable for range-checked inputs; terminate rather than run past December.
          state_nxt_s = DONE;
          err_nxt_s   = 1'b1;
          month_nxt_s = 4'd0;
          date_nxt_s  = 5'd0;
        end else begin
          rem_nxt_s  = rem_r - DAY_W'(len_s);
          mcnt_nxt_s = mcnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s == CALC);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // State and registered outputs; reset lands on 1 January.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      rem_r   <= '0;
      mcnt_r  <= 4'd1;
      leap_r  <= 1'b0;
      month_r <= 4'd1;
      date_r  <= 5'd1;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
      mcnt_r  <= mcnt_nxt_s;
      leap_r  <= leap_nxt_s;
      month_r <= month_nxt_s;
      date_r  <= date_nxt_s;
      err_r   <= err_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign err   = err_r;
  assign month = month_r;
  assign date  = date_r;

endmodule

// File: tb/tb_day_to_date.sv
// Bench for day_to_date: calendar reference model checked every cycle, plus
// directed conversions with hand-computed month/date/latency.
module tb_day_to_date;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [8:0] day_idx;
  logic       leap;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] month;
  logic [4:0] date;

  int vectors;
  int miscompares;

  day_to_date #(.DAY_W(9)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .day_idx (day_idx),
    .leap    (leap),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .month   (month),
    .date    (date)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Calendar lookup via first-day-of-month offsets.
  function automatic void expect_of(input int day, input bit lp, output int m, output int d);
    int ml[12];
    int cum[13];
    ml = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (lp) ml[1] = 29;
    cum[1] = 0;
    for (int k = 2; k <= 12; k++) cum[k] = cum[k-1] + ml[k-2];
    m = 0;
    d = 0;
    for (int k = 12; k >= 1; k--) begin
      if (m == 0 && day >= cum[k]) begin
        m = k;
        d = day - cum[k] + 1;
      end
    end
  endfunction

  // Reference model: a conversion of month m keeps busy for m cycles then pulses done.
  int         cnt;
  int         pend_m, pend_d;
  logic       exp_busy, exp_done, exp_err;
  logic [3:0] exp_month;
  logic [4:0] exp_date;

  always @(posedge clk or negedge rst_n) begin
    int c, pm, pd;
    logic dn, er;
    logic [3:0] mo;
    logic [4:0] da;
    if (!rst_n) begin
      cnt       <= 0;
      exp_busy  <= 1'b0;
      exp_done  <= 1'b0;
      exp_err   <= 1'b0;
      exp_month <= 4'd1;
      exp_date  <= 5'd1;
    end else begin
      c  = cnt;
      dn = 1'b0;
      er = exp_err;
      mo = exp_month;
      da = exp_date;
      if (c > 0) begin
        c = c - 1;
        if (c == 0) begin
          dn = 1'b1;
          mo = 4'(pend_m);
          da = 5'(pend_d);
        end
      end else if (start) begin
        er = 1'b0;
        if (int'(day_idx) >= 365 + int'(leap)) begin
          dn = 1'b1;
          er = 1'b1;
          mo = 4'd0;
          da = 5'd0;
        end else begin
          expect_of(int'(day_idx), leap, pm, pd);
          pend_m <= pm;
          pend_d <= pd;
          c = pm;
        end
      end
      cnt       <= c;
      exp_busy  <= (c > 0);
      exp_done  <= dn;
      exp_err   <= er;
      exp_month <= mo;
      exp_date  <= da;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    vectors++;
    if (busy !== exp_busy || done !== exp_done || err !== exp_err ||
        month !== exp_month || date !== exp_date) begin
      miscompares++;
      $display("FAIL cycle_cmp t=%0t got busy=%b done=%b err=%b month=%0d date=%0d, want busy=%b done=%b err=%b month=%0d date=%0d",
               $time, busy, done, err, month, date, exp_busy, exp_done, exp_err, exp_month, exp_date);
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic start_conv(input int day, input bit lp);
    start   = 1'b1;
    day_idx = 9'(day);
    leap    = lp;
  endtask

  // Called at a negedge right after start_conv; waits for done and checks the literal result.
  task automatic wait_done(input string name, input int m, input int d, input int e,
                           input int lat, input int pulse_at);
    int k;
    bit seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 1) start = 1'b0;
      if (k == pulse_at) start_conv(5, 1'b1);
      if (k == pulse_at + 1) start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout got no done within 20 cycles want done", name);
    end else begin
      check({name, "_lat"}, k, lat);
      check({name, "_month"}, int'(month), m);
      check({name, "_date"}, int'(date), d);
      check({name, "_err"}, int'(err), e);
      check({name, "_busy"}, int'(busy), 0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    day_idx = 9'd0;
    leap    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_month", int'(month), 1);
    check("rst_date", int'(date), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);

    start_conv(0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("jan1_busy_c1", int'(busy), 1);
    @(negedge clk);
    check("jan1_done_c2", int'(done), 1);
    check("jan1_month", int'(month), 1);
    check("jan1_date", int'(date), 1);
    check("jan1_busy_c2", int'(busy), 0);
    @(negedge clk);

    start_conv(59, 1'b0);  wait_done("d59", 3, 1, 0, 4, 0);   @(negedge clk);
    start_conv(59, 1'b1);  wait_done("d59l", 2, 29, 0, 3, 0); @(negedge clk);
    start_conv(364, 1'b0); wait_done("d364", 12, 31, 0, 13, 0); @(negedge clk);
    start_conv(365, 1'b1); wait_done("d365l", 12, 31, 0, 13, 0); @(negedge clk);
    start_conv(181, 1'b0); wait_done("d181", 7, 1, 0, 8, 0);  @(negedge clk);
    start_conv(365, 1'b0); wait_done("err365", 0, 0, 1, 1, 0); @(negedge clk);
    check("err_held", int'(err), 1);
    start_conv(366, 1'b1); wait_done("err366l", 0, 0, 1, 1, 0); @(negedge clk);
    start_conv(45, 1'b0);  wait_done("clr_err", 2, 15, 0, 3, 0); @(negedge clk);

    start_conv(300, 1'b0); wait_done("ignore", 10, 28, 0, 11, 3);
    start_conv(31, 1'b0);  wait_done("b2b", 2, 1, 0, 3, 0);
    repeat (2) @(negedge clk);

    start_conv(364, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_month", int'(month), 1);
    check("midrst_date", int'(date), 1);
    check("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("midrst_no_done", int'(done), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
